// File: rtl/pfc_reset_sequencer_if.sv
// Avalon-MM slave bus bundle for pfc_reset_sequencer (3-bit word address, 32-bit data).
interface pfc_reset_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pfc_reset_sequencer.sv
// Staggered assert/hold/release reset generator for the PFC peripherals, Avalon-MM controlled.
// Define PFC_RSTSEQ_IRQ_EN to add the irq port and the CONTROL b2 interrupt mask.
module pfc_reset_sequencer #(
  parameter int unsigned NUM_OUT      = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HOLD = 100,
  parameter int unsigned DEFAULT_GAP  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pfc_reset_sequencer_if.slave avs,
  output logic [NUM_OUT-1:0]   rst_out
`ifdef PFC_RSTSEQ_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE} state_t;

  localparam logic [CNT_W-1:0] RST_HOLD  = (DEFAULT_HOLD == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HOLD);
  localparam logic [2:0]       LAST_STEP = 3'(NUM_OUT - 1);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   hold_q, gap_q;
  logic [CNT_W-1:0]   gap_s_q, gap_s_n, cnt_q, cnt_n, gap_cnt_q, gap_cnt_n;
  logic [NUM_OUT-1:0] enable_q, enable_n, seq_q, seq_n, rst_out_n;
  logic [2:0]         step_q, step_n;
  logic               force_q, force_n, done_q, done_n;
  logic               wr, wr_ctrl, wr_hold, wr_gap, wr_status, wr_enable, start;
  logic [31:0]        rdata;

  assign wr        = avs.chipselect && !avs.write_n;
  assign wr_ctrl   = wr && (avs.address == 3'd0);
  assign wr_hold   = wr && (avs.address == 3'd1);
  assign wr_gap    = wr && (avs.address == 3'd2);
  assign wr_status = wr && (avs.address == 3'd3);
  assign wr_enable = wr && (avs.address == 3'd4);

  assign force_n  = wr_ctrl ? avs.writedata[1] : force_q;
  assign enable_n = wr_enable ? avs.writedata[NUM_OUT-1:0] : enable_q;
  // A frozen (forced) FSM does not accept START, even from IDLE.
  assign start    = wr_ctrl && avs.writedata[0] && (state_q == S_IDLE) && !force_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q   <= CNT_W'(DEFAULT_HOLD);
      gap_q    <= CNT_W'(DEFAULT_GAP);
      enable_q <= '1;
      force_q  <= 1'b0;
    end else begin
      if (wr_hold) hold_q <= avs.writedata[CNT_W-1:0];
      if (wr_gap)  gap_q  <= avs.writedata[CNT_W-1:0];
      enable_q <= enable_n;
      force_q  <= force_n;
    end
  end

`ifdef PFC_RSTSEQ_IRQ_EN
  logic irqmask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irqmask_q <= 1'b0;
    else if (wr_ctrl) irqmask_q <= avs.writedata[2];
  end

  assign irq = done_q & irqmask_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_ASSERT;
      cnt_q     <= RST_HOLD;
      gap_cnt_q <= '0;
      gap_s_q   <= CNT_W'(DEFAULT_GAP);
      step_q    <= '0;
      seq_q     <= '1;
      done_q    <= 1'b0;
      rst_out   <= '1;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      gap_cnt_q <= gap_cnt_n;
      gap_s_q   <= gap_s_n;
      step_q    <= step_n;
      seq_q     <= seq_n;
      done_q    <= done_n;
      rst_out   <= rst_out_n;
    end
  end

  // seq_q carries the sequence's own view of the outputs so FORCE can override
  // rst_out and the sequence resumes with its bits intact afterwards.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    gap_cnt_n = gap_cnt_q;
    gap_s_n   = gap_s_q;
    step_n    = step_q;
    seq_n     = seq_q;
    done_n    = done_q;
    if (!force_q) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_n = S_ASSERT;
            seq_n   = enable_q;
            cnt_n   = (hold_q == '0) ? CNT_W'(1) : hold_q;
            gap_s_n = gap_q;
          end
        end
        S_ASSERT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_n   = S_RELEASE;
            step_n    = '0;
            gap_cnt_n = '0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (gap_cnt_q == '0) begin
            seq_n     = seq_q & ~(NUM_OUT'(1) << step_q);
            gap_cnt_n = gap_s_q;
            step_n    = step_q + 3'd1;
            if (step_q == LAST_STEP) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end else begin
            gap_cnt_n = gap_cnt_q - CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (wr_status && avs.writedata[1]) done_n = 1'b0;
    rst_out_n = force_n ? enable_n : seq_n;
  end

  always_comb begin
    rdata = '0;
    case (avs.address)
      3'd0: begin
        rdata[1] = force_q;
`ifdef PFC_RSTSEQ_IRQ_EN
        rdata[2] = irqmask_q;
`endif
      end
      3'd1: rdata[CNT_W-1:0] = hold_q;
      3'd2: rdata[CNT_W-1:0] = gap_q;
      3'd3: begin
        rdata[0]            = (state_q != S_IDLE);
        rdata[1]            = done_q;
        rdata[8 +: NUM_OUT] = rst_out;
      end
      3'd4: rdata[NUM_OUT-1:0] = enable_q;
      default: rdata = '0;
    endcase
  end

  assign avs.readdata = rdata;

endmodule
